proc_in_fifo: RTL and testbench
===============================

Name: proc_in_fifo

Overview:
- Input sample buffer directly upstream of the processor wrapper's `in`/`req_in` port.
- Accepts samples from an ADC/stream source over a valid/ready handshake and stores them in a circular FIFO.
- Presents the head sample combinationally to the processor and pops one entry on each `req_in` pulse.
- A prime/starve state machine keeps the processor from consuming data before the buffer holds a safe level.

Parameters:
- NUBITS, 32: sample width; matches the processor data width.
- DEPTH, 16: FIFO entries; power of 2, 2..256.
- PRIME_LVL, 8: fill level required to enter or re-enter RUN; 1..DEPTH.
- AW (localparam), $clog2(DEPTH): pointer width.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- s_data, in, NUBITS signed: source sample.
- s_valid, in, 1: source sample valid.
- s_ready, out, 1: FIFO can accept a sample.
- req_in, in, 1: processor read strobe, 1 cycle per read.
- dout, out, NUBITS signed: sample to the processor `in` port.
- primed, out, 1: high while the state is RUN.
- level, out, AW+1: current occupancy, 0..DEPTH.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is asynchronous and active-low. All state resets immediately on `rst`=0.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, hold=0, state=FILL, s_ready=1, primed=0, dout=0. Memory contents are not reset.
- Push: on a clock edge with s_valid && s_ready, write mem[wr_ptr], then wr_ptr++ (wraps at DEPTH-1 -> 0).
- Ready: s_ready = (level != DEPTH), combinational from level. No push when full, even if a pop occurs in the same cycle.
- Pop: on a clock edge with req_in && state==RUN && level!=0, rd_ptr++ (wraps) and hold <= mem[rd_ptr].
- Simultaneous push and pop: level is unchanged; both pointers advance.
- dout is combinational and valid in the same cycle as req_in, because the processor samples it there:
  - FILL: dout = 0.
  - RUN with level != 0: dout = mem[rd_ptr].
  - STARVED, or RUN with level == 0: dout = hold (the last popped sample).
- FSM:
  - FILL -> RUN when level >= PRIME_LVL, evaluated on the registered level.
  - RUN -> STARVED when req_in && level == 0. No pop occurs; hold is presented.
  - STARVED -> RUN when level >= PRIME_LVL.
  - In FILL and STARVED, req_in never pops.
- Latency: a sample pushed at edge N is visible on dout from cycle N+1 if the FIFO was empty and the state is RUN.
- Boundary cases:
  - PRIME_LVL = DEPTH is legal; RUN is entered only when full.
  - level saturates naturally, since push is gated when full and pop is gated when empty.
  - Reset mid-stream discards all contents and returns to FILL.

Optional Feature:
- Macro: PROC_IN_FIFO_STATS_EN.
- Defined:
  - Adds output ports ovf_cnt[15:0] and unf_cnt[15:0], both reset to 0 and saturating at 16'hFFFF.
  - ovf_cnt increments on s_valid && !s_ready.
  - unf_cnt increments on req_in when no pop occurs (FILL, STARVED, or empty).
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package (proc_io_pkg) holds:
  - FSM state encoding: FILL=2'd0, RUN=2'd1, STARVED=2'd2.
  - Counter width constant STAT_W=16.
- One natural sub-module: fifo_mem_dp, a simple dual-port register array (write port plus asynchronous read port), parameterised by NUBITS and DEPTH.
- The FSM, pointers and counters stay in proc_in_fifo.

Test Plan:
- Reset and prime: DEPTH=16, PRIME_LVL=8; push 1..7 -> primed=0, dout=0, level=7. Push 8 -> primed=1 on the next cycle, dout=1.
- Read order: in RUN with 8 entries, pulse req_in 3 times -> dout shows 1, 2, 3 in the pulse cycles; level=5; hold=3.
- Full: push 16 samples with no reads -> level=16, s_ready=0. A 17th s_valid is not accepted; with stats enabled, ovf_cnt=1.
- Starvation: drain to empty, then pulse req_in -> state STARVED, dout equals the last sample, level stays 0, unf_cnt+1. Push 8 more -> RUN resumes with the first new sample.
- Simultaneous push and pop at level=5 -> level stays 5; both pointers advance; wrap across index 15 -> 0 keeps order intact.
- Asynchronous reset: assert rst=0 mid-cycle while level=10 -> immediately level=0, primed=0, dout=0, s_ready=1, without waiting for a clock edge.

Source files
------------

// File: rtl/proc_io_pkg.sv
// Shared definitions for the processor input buffer: FSM state encoding and
// statistics counter width.
package proc_io_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } fifo_state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port.
module fifo_mem_dp #(
    parameter int NUBITS = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [NUBITS-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [NUBITS-1:0] rdata
);

    logic signed [NUBITS-1:0] mem [DEPTH];

    // NOTE: the array has no reset; occupancy tracking alone determines which
    // entries are meaningful, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/proc_in_fifo.sv
// Input sample buffer feeding the processor, with a FILL/RUN/STARVED priming FSM.
// Define PROC_IN_FIFO_STATS_EN to add saturating overflow/underflow counters.
module proc_in_fifo
    import proc_io_pkg::*;
#(
    parameter int NUBITS    = 32,
    parameter int DEPTH     = 16,
    parameter int PRIME_LVL = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [NUBITS-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     req_in,
    output logic signed [NUBITS-1:0] dout,
    output logic                     primed,
    output logic [AW:0]              level
`ifdef PROC_IN_FIFO_STATS_EN
    ,
    output logic [STAT_W-1:0]        ovf_cnt,
    output logic [STAT_W-1:0]        unf_cnt
`endif
);

    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_THR = (AW+1)'(PRIME_LVL);

    fifo_state_t              state, state_nxt;
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic signed [NUBITS-1:0] hold, head;
    logic                     push, pop;

    assign s_ready = (level != FULL_LVL);
    assign push    = s_valid && s_ready;
    assign pop     = req_in && (state == RUN) && (level != '0);

    fifo_mem_dp #(
        .NUBITS(NUBITS),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(s_data),
        .raddr(rd_ptr),
        .rdata(head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        dout      = hold;
        unique case (state)
            FILL: begin
                dout = '0;
                if (level >= PRIME_THR) state_nxt = RUN;
            end
            RUN: begin
                if (level != '0)          dout = head;
                else if (req_in)          state_nxt = STARVED;
            end
            STARVED: begin
                if (level >= PRIME_THR) state_nxt = RUN;
            end
            default: begin
                dout      = '0;
                state_nxt = FILL;
            end
        endcase
    end

    assign primed = (state == RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            hold   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= head;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef PROC_IN_FIFO_STATS_EN
    // Refused source samples and read strobes that did not pop, both saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else begin
            if (s_valid && !s_ready && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
            if (req_in && !pop && (unf_cnt != '1))      unf_cnt <= unf_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_proc_in_fifo.sv
// Directed self-checking bench for proc_in_fifo with hand-computed expectations.
module tb_proc_in_fifo;

    localparam int NUBITS    = 32;
    localparam int DEPTH     = 16;
    localparam int PRIME_LVL = 8;
    localparam int AW        = $clog2(DEPTH);

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [NUBITS-1:0] s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic                     req_in;
    logic signed [NUBITS-1:0] dout;
    logic                     primed;
    logic [AW:0]              level;
`ifdef PROC_IN_FIFO_STATS_EN
    logic [15:0]              ovf_cnt;
    logic [15:0]              unf_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    proc_in_fifo #(
        .NUBITS   (NUBITS),
        .DEPTH    (DEPTH),
        .PRIME_LVL(PRIME_LVL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .req_in (req_in),
        .dout   (dout),
        .primed (primed),
        .level  (level)
`ifdef PROC_IN_FIFO_STATS_EN
        ,
        .ovf_cnt(ovf_cnt),
        .unf_cnt(unf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        s_valid = 1'b1;
        s_data  = v;
        step();
        s_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int exp);
        req_in = 1'b1;
        #1;
        check(tag, dout, exp);
        step();
        req_in = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        req_in  = 1'b0;
        #2;
        check("rst_level", level, 0);
        check("rst_primed", primed, 0);
        check("rst_dout", dout, 0);
        check("rst_ready", s_ready, 1);
        #10 rst = 1'b1;
        step();

        // Priming: seven samples stay in FILL, the eighth arms RUN one edge later.
        for (int i = 1; i <= 7; i++) push(i);
        check("fill7_level", level, 7);
        check("fill7_primed", primed, 0);
        check("fill7_dout", dout, 0);
        push(8);
        check("fill8_level", level, 8);
        check("fill8_primed_lag", primed, 0);
        step();
        check("run_primed", primed, 1);
        check("run_head", dout, 1);

        pop_chk("read1", 1);
        pop_chk("read2", 2);
        pop_chk("read3", 3);
        check("read_level", level, 5);

        // Simultaneous push and pop; write pointer wraps 15 -> 0 along the way.
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 9 + i;
            req_in  = 1'b1;
            #1;
            check("simul_dout", dout, 4 + i);
            step();
        end
        s_valid = 1'b0;
        req_in  = 1'b0;
        check("simul_level", level, 5);

        // Drain; read pointer wraps between 16 (index 15) and 17 (index 0).
        for (int v = 14; v <= 18; v++) pop_chk("drain", v);
        check("empty_level", level, 0);
        check("empty_primed", primed, 1);
        check("empty_hold", dout, 18);

        req_in = 1'b1;
        #1;
        check("starve_dout", dout, 18);
        step();
        req_in = 1'b0;
        check("starve_primed", primed, 0);
        check("starve_level", level, 0);
        check("starve_hold", dout, 18);
`ifdef PROC_IN_FIFO_STATS_EN
        check("unf_cnt", unf_cnt, 1);
`endif

        // Refill to full: RUN resumes with the first new sample.
        for (int i = 0; i < 16; i++) push(100 + i);
        check("full_level", level, 16);
        check("full_ready", s_ready, 0);
        check("resume_primed", primed, 1);
        check("resume_head", dout, 100);

        s_valid = 1'b1;
        s_data  = 999;
        #1;
        check("full_ready_hold", s_ready, 0);
        step();
        s_valid = 1'b0;
        check("full_no_push", level, 16);
`ifdef PROC_IN_FIFO_STATS_EN
        check("ovf_cnt1", ovf_cnt, 1);
`endif

        // Full with push and pop together: only the pop takes effect.
        s_valid = 1'b1;
        s_data  = 777;
        req_in  = 1'b1;
        #1;
        check("full_pop_dout", dout, 100);
        step();
        s_valid = 1'b0;
        req_in  = 1'b0;
        check("full_pop_level", level, 15);
`ifdef PROC_IN_FIFO_STATS_EN
        check("ovf_cnt2", ovf_cnt, 2);
`endif
        for (int v = 101; v <= 115; v++) pop_chk("full_drain", v);
        check("full_drain_level", level, 0);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 10; i++) push(200 + i);
        check("pre_rst_level", level, 10);
        check("pre_rst_primed", primed, 1);
        check("pre_rst_dout", dout, 200);
        #2 rst = 1'b0;
        #1;
        check("arst_level", level, 0);
        check("arst_primed", primed, 0);
        check("arst_dout", dout, 0);
        check("arst_ready", s_ready, 1);
`ifdef PROC_IN_FIFO_STATS_EN
        check("arst_ovf", ovf_cnt, 0);
        check("arst_unf", unf_cnt, 0);
`endif
        #3 rst = 1'b1;
        step();
        push(55);
        check("post_rst_level", level, 1);
        check("post_rst_primed", primed, 0);
        check("post_rst_dout", dout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
